// File: rtl/jellyvl_synctimer_limitter_hys_if.sv
// ---------------------------------------------------------------------------
// jellyvl_synctimer_limitter_hys_if
//   Sample bus into and out of the sync-timer correction limiter.
//   Correction side : correct_time, correct_renew, correct_valid
//   Result side     : out_diff, out_renew, out_over, out_under, out_valid
//   master = correction source / downstream consumer
//   slave  = the limiter itself
// ---------------------------------------------------------------------------
interface jellyvl_synctimer_limitter_hys_if #(
   parameter int TIMER_WIDTH = 64,
   parameter int LIMIT_WIDTH = TIMER_WIDTH
);
   logic        [TIMER_WIDTH-1:0] correct_time;
   logic                          correct_renew;
   logic                          correct_valid;

   logic signed [LIMIT_WIDTH-1:0] out_diff;
   logic                          out_renew;
   logic                          out_over;
   logic                          out_under;
   logic                          out_valid;

   modport master (
      output correct_time, correct_renew, correct_valid,
      input  out_diff, out_renew, out_over, out_under, out_valid
   );

   modport slave (
      input  correct_time, correct_renew, correct_valid,
      output out_diff, out_renew, out_over, out_under, out_valid
   );
endinterface

// File: rtl/jellyvl_synctimer_limitter_hys.sv
// ---------------------------------------------------------------------------
// jellyvl_synctimer_limitter_hys
//   Correction-range limiter with renewal hysteresis. Each correction sample
//   is turned into a signed offset from the local timer, clamped to
//   [param_limit_min, param_limit_max] and flagged over/under. A full timer
//   renewal is requested only after param_renew_count consecutive
//   out-of-range samples.
//
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     param_enable       enables violation counting / renewal trigger
//     param_limit_min    signed lower bound of accepted offset
//     param_limit_max    signed upper bound of accepted offset
//     param_renew_count  consecutive violations for renewal (0 acts as 1)
//     current_time       local timer
//     bus (slave)        correction sample in, clamped result out
//     request_renew      level request for a renewal sample
//     status_count       current consecutive-violation count
//
//   Pipeline: stage 1 registers the raw offset, stage 2 registers the
//   clamped result, the counter and the renewal request.
//   LIMIT_WIDTH must not exceed TIMER_WIDTH.
// ---------------------------------------------------------------------------
module jellyvl_synctimer_limitter_hys #(
   parameter int   TIMER_WIDTH   = 64,
   parameter int   LIMIT_WIDTH   = TIMER_WIDTH,
   parameter int   COUNT_WIDTH   = 8,
   parameter logic INIT_OVERRIDE = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst_n,

   input  logic                          param_enable,
   input  logic signed [LIMIT_WIDTH-1:0] param_limit_min,
   input  logic signed [LIMIT_WIDTH-1:0] param_limit_max,
   input  logic        [COUNT_WIDTH-1:0] param_renew_count,

   input  logic        [TIMER_WIDTH-1:0] current_time,
   jellyvl_synctimer_limitter_hys_if.slave bus,

   output logic                          request_renew,
   output logic        [COUNT_WIDTH-1:0] status_count
);

   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

   // Stage 1
   logic signed [TIMER_WIDTH-1:0] diff_q;
   logic                          renew_q;
   logic                          valid_q;

   // Stage 2 / state
   logic signed [LIMIT_WIDTH-1:0] out_diff_q;
   logic                          out_renew_q;
   logic                          out_over_q;
   logic                          out_under_q;
   logic                          out_valid_q;
   logic        [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                          request_q, request_d;

   // Combinational compare
   logic signed [TIMER_WIDTH-1:0] lim_min_ext;
   logic signed [TIMER_WIDTH-1:0] lim_max_ext;
   logic                          under;
   logic                          over;
   logic                          violate;
   logic        [COUNT_WIDTH-1:0] thresh;
   logic        [COUNT_WIDTH:0]   cnt_plus1;
   logic                          trigger;
   logic signed [LIMIT_WIDTH-1:0] diff_clamped;

   // The subtraction wraps modulo 2^TIMER_WIDTH, so a timer rollover between
   // current_time and correct_time still yields the small signed offset.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, whatever order the blocks run in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff_q  <= '0;
         renew_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         diff_q  <= bus.correct_time - current_time;
         renew_q <= bus.correct_renew;
         valid_q <= bus.correct_valid;
      end
   end

   // Signed size casts sign-extend the limits to the timer width.
   assign lim_min_ext = TIMER_WIDTH'(param_limit_min);
   assign lim_max_ext = TIMER_WIDTH'(param_limit_max);

   // under takes priority, so an inverted window (min > max) always flags.
   assign under   = diff_q < lim_min_ext;
   assign over    = !under && (diff_q > lim_max_ext);
   assign violate = under | over;

   assign thresh    = (param_renew_count == '0) ? COUNT_WIDTH'(1) : param_renew_count;
   // One extra bit so a saturated counter still compares as count + 1.
   assign cnt_plus1 = {1'b0, cnt_q} + (COUNT_WIDTH + 1)'(1);
   assign trigger   = valid_q && param_enable && violate && (cnt_plus1 >= {1'b0, thresh});

   assign diff_clamped = under ? param_limit_min :
                         over  ? param_limit_max :
                                 LIMIT_WIDTH'(diff_q);

   // NOTE: every variable written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (valid_q) begin
         if (renew_q || !param_enable) begin
            cnt_d = '0;
         end else if (violate) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_plus1[COUNT_WIDTH-1:0];
         end else begin
            cnt_d = '0;
         end
      end
   end

   // A new accepted sample clears the request; a trigger from the sample
   // already in stage 1 on the same edge overrides that clear.
   always_comb begin
      request_d = request_q;
      if (bus.correct_valid) begin
         request_d = 1'b0;
      end
      if (trigger) begin
         request_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_diff_q  <= '0;
         out_renew_q <= 1'b0;
         out_over_q  <= 1'b0;
         out_under_q <= 1'b0;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
         request_q   <= INIT_OVERRIDE;
      end else begin
         out_valid_q <= valid_q;
         if (valid_q) begin
            out_diff_q  <= diff_clamped;
            out_renew_q <= renew_q;
            out_over_q  <= over;
            out_under_q <= under;
         end
         cnt_q     <= cnt_d;
         request_q <= request_d;
      end
   end

   assign bus.out_diff   = out_diff_q;
   assign bus.out_renew  = out_renew_q;
   assign bus.out_over   = out_over_q;
   assign bus.out_under  = out_under_q;
   assign bus.out_valid  = out_valid_q;
   assign request_renew  = request_q;
   assign status_count   = cnt_q;

endmodule

// File: tb/tb_jellyvl_synctimer_limitter_hys.sv
// ---------------------------------------------------------------------------
// tb_jellyvl_synctimer_limitter_hys
//   Directed bench for the correction limiter. A default instance (64-bit
//   timer and limits, 8-bit counter) and a second instance with a 2-bit
//   counter see the same stimulus; the second one covers saturation.
// ---------------------------------------------------------------------------
module tb_jellyvl_synctimer_limitter_hys;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               param_enable;
   logic signed [63:0] param_limit_min;
   logic signed [63:0] param_limit_max;
   logic        [7:0]  param_renew_count;
   logic        [1:0]  param_renew_count_s;
   logic        [63:0] current_time;
   logic               request_renew, request_renew_s;
   logic        [7:0]  status_count;
   logic        [1:0]  status_count_s;

   int vectors = 0;
   int errors  = 0;

   jellyvl_synctimer_limitter_hys_if #(.TIMER_WIDTH(64), .LIMIT_WIDTH(64)) bus   ();
   jellyvl_synctimer_limitter_hys_if #(.TIMER_WIDTH(64), .LIMIT_WIDTH(64)) bus_s ();

   assign bus_s.correct_time  = bus.correct_time;
   assign bus_s.correct_renew = bus.correct_renew;
   assign bus_s.correct_valid = bus.correct_valid;
   assign param_renew_count_s = param_renew_count[1:0];

   jellyvl_synctimer_limitter_hys #(
      .TIMER_WIDTH(64), .LIMIT_WIDTH(64), .COUNT_WIDTH(8), .INIT_OVERRIDE(1'b1)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .param_enable      (param_enable),
      .param_limit_min   (param_limit_min),
      .param_limit_max   (param_limit_max),
      .param_renew_count (param_renew_count),
      .current_time      (current_time),
      .bus               (bus.slave),
      .request_renew     (request_renew),
      .status_count      (status_count)
   );

   jellyvl_synctimer_limitter_hys #(
      .TIMER_WIDTH(64), .LIMIT_WIDTH(64), .COUNT_WIDTH(2), .INIT_OVERRIDE(1'b1)
   ) dut_s (
      .clk               (clk),
      .rst_n             (rst_n),
      .param_enable      (param_enable),
      .param_limit_min   (param_limit_min),
      .param_limit_max   (param_limit_max),
      .param_renew_count (param_renew_count_s),
      .current_time      (current_time),
      .bus               (bus_s.slave),
      .request_renew     (request_renew_s),
      .status_count      (status_count_s)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one isolated sample with the given offset; returns once its
   // stage-2 result is visible.
   task automatic apply(input longint d);
      current_time       = 64'd1000;
      bus.correct_time   = 64'(64'sd1000 + d);
      bus.correct_renew  = 1'b0;
      bus.correct_valid  = 1'b1;
      tick();
      bus.correct_valid  = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      tick();
      vectors++; if (request_renew !== 1'b1) begin errors++; $display("FAIL rst_request got %b want 1", request_renew); end
      vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.out_valid); end
      vectors++; if (bus.out_diff !== 64'sd0) begin errors++; $display("FAIL rst_diff got %0d want 0", bus.out_diff); end
      vectors++; if (status_count !== 8'd0) begin errors++; $display("FAIL rst_count got %0d want 0", status_count); end
      rst_n = 1'b1;
      tick();
      // First sample is a renewal.
      current_time      = 64'd500;
      bus.correct_time  = 64'd500;
      bus.correct_renew = 1'b1;
      bus.correct_valid = 1'b1;
      tick();
      vectors++; if (request_renew !== 1'b0) begin errors++; $display("FAIL first_clear got %b want 0", request_renew); end
      vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL first_early_valid got %b want 0", bus.out_valid); end
      bus.correct_valid = 1'b0;
      bus.correct_renew = 1'b0;
      tick();
      vectors++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", bus.out_valid); end
      vectors++; if (bus.out_renew !== 1'b1) begin errors++; $display("FAIL first_renew got %b want 1", bus.out_renew); end
   endtask

   task automatic test_in_range();
      apply(50);
      vectors++; if (bus.out_diff !== 64'sd50) begin errors++; $display("FAIL inr_diff got %0d want 50", bus.out_diff); end
      vectors++; if ({bus.out_over, bus.out_under, bus.out_renew} !== 3'b000) begin errors++; $display("FAIL inr_flags got %b want 000", {bus.out_over, bus.out_under, bus.out_renew}); end
      vectors++; if (status_count !== 8'd0) begin errors++; $display("FAIL inr_count got %0d want 0", status_count); end
      vectors++; if (request_renew !== 1'b0) begin errors++; $display("FAIL inr_request got %b want 0", request_renew); end
      tick();
      vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", bus.out_valid); end
      vectors++; if (bus.out_diff !== 64'sd50) begin errors++; $display("FAIL idle_hold got %0d want 50", bus.out_diff); end
   endtask

   task automatic test_threshold();
      param_renew_count = 8'd3;
      for (int i = 0; i < 3; i++) begin
         apply(500);
         vectors++; if (bus.out_diff !== 64'sd100) begin errors++; $display("FAIL thr_diff[%0d] got %0d want 100", i, bus.out_diff); end
         vectors++; if (bus.out_over !== 1'b1) begin errors++; $display("FAIL thr_over[%0d] got %b want 1", i, bus.out_over); end
         vectors++; if (status_count !== 8'(i + 1)) begin errors++; $display("FAIL thr_count[%0d] got %0d want %0d", i, status_count, i + 1); end
         vectors++; if (request_renew !== (i == 2)) begin errors++; $display("FAIL thr_request[%0d] got %b want %b", i, request_renew, i == 2); end
      end
      // Any accepted sample clears the request one edge later.
      current_time      = 64'd1000;
      bus.correct_time  = 64'd1000;
      bus.correct_valid = 1'b1;
      tick();
      vectors++; if (request_renew !== 1'b0) begin errors++; $display("FAIL thr_clear got %b want 0", request_renew); end
      bus.correct_valid = 1'b0;
      tick();
      vectors++; if (status_count !== 8'd0) begin errors++; $display("FAIL thr_count_clear got %0d want 0", status_count); end
   endtask

   task automatic test_counter_reset();
      longint diffs [4] = '{-300, -300, 0, -300};
      logic [7:0] exp_cnt [4] = '{8'd1, 8'd2, 8'd0, 8'd1};
      for (int i = 0; i < 4; i++) begin
         apply(diffs[i]);
         vectors++; if (status_count !== exp_cnt[i]) begin errors++; $display("FAIL crst_count[%0d] got %0d want %0d", i, status_count, exp_cnt[i]); end
         vectors++; if (request_renew !== 1'b0) begin errors++; $display("FAIL crst_request[%0d] got %b want 0", i, request_renew); end
         if (i == 0) begin
            vectors++; if (bus.out_diff !== -64'sd100) begin errors++; $display("FAIL crst_diff got %0d want -100", bus.out_diff); end
            vectors++; if (bus.out_under !== 1'b1) begin errors++; $display("FAIL crst_under got %b want 1", bus.out_under); end
         end
      end
   endtask

   task automatic test_wrap();
      current_time      = 64'hFFFF_FFFF_FFFF_FFF0;
      bus.correct_time  = 64'h0000_0000_0000_0010;
      bus.correct_valid = 1'b1;
      tick();
      bus.correct_valid = 1'b0;
      tick();
      vectors++; if (bus.out_diff !== 64'sd32) begin errors++; $display("FAIL wrap_diff got %0d want 32", bus.out_diff); end
      vectors++; if ({bus.out_over, bus.out_under} !== 2'b00) begin errors++; $display("FAIL wrap_flags got %b want 00", {bus.out_over, bus.out_under}); end
   endtask

   task automatic test_back_to_back();
      param_renew_count = 8'd1;
      current_time      = 64'd1000;
      bus.correct_time  = 64'd1500;
      bus.correct_valid = 1'b1;
      tick();
      // Violator now in stage 1; next sample arrives on the edge it triggers.
      bus.correct_time  = 64'd1007;
      tick();
      vectors++; if (request_renew !== 1'b1) begin errors++; $display("FAIL b2b_setwins got %b want 1", request_renew); end
      vectors++; if (bus.out_over !== 1'b1) begin errors++; $display("FAIL b2b_over got %b want 1", bus.out_over); end
      bus.correct_valid = 1'b0;
      tick();
      vectors++; if (request_renew !== 1'b1) begin errors++; $display("FAIL b2b_hold got %b want 1", request_renew); end
      vectors++; if (bus.out_diff !== 64'sd7 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second got %0d/%b want 7/1", bus.out_diff, bus.out_valid); end
      vectors++; if (status_count !== 8'd0) begin errors++; $display("FAIL b2b_count got %0d want 0", status_count); end
      bus.correct_time  = 64'd1000;
      bus.correct_renew = 1'b1;
      bus.correct_valid = 1'b1;
      tick();
      vectors++; if (request_renew !== 1'b0) begin errors++; $display("FAIL b2b_clear got %b want 0", request_renew); end
      bus.correct_valid = 1'b0;
      bus.correct_renew = 1'b0;
      tick();
   endtask

   task automatic test_disable();
      param_enable = 1'b0;
      for (int i = 0; i < 2; i++) begin
         apply(500);
         vectors++; if (status_count !== 8'd0) begin errors++; $display("FAIL dis_count[%0d] got %0d want 0", i, status_count); end
         vectors++; if (request_renew !== 1'b0) begin errors++; $display("FAIL dis_request[%0d] got %b want 0", i, request_renew); end
         vectors++; if (bus.out_over !== 1'b1 || bus.out_diff !== 64'sd100) begin errors++; $display("FAIL dis_flags[%0d] got %b/%0d want 1/100", i, bus.out_over, bus.out_diff); end
      end
      // Inverted window: every sample flags.
      param_limit_min = 64'sd10;
      param_limit_max = -64'sd10;
      apply(0);
      vectors++; if (bus.out_under !== 1'b1 || bus.out_diff !== 64'sd10) begin errors++; $display("FAIL inv_under got %b/%0d want 1/10", bus.out_under, bus.out_diff); end
      apply(20);
      vectors++; if (bus.out_over !== 1'b1 || bus.out_under !== 1'b0 || bus.out_diff !== -64'sd10) begin errors++; $display("FAIL inv_over got %b%b/%0d want 10/-10", bus.out_over, bus.out_under, bus.out_diff); end
      param_limit_min = -64'sd100;
      param_limit_max = 64'sd100;
      param_enable    = 1'b1;
   endtask

   task automatic test_saturation();
      param_renew_count = 8'd0;
      for (int i = 0; i < 5; i++) begin
         apply(-300);
         vectors++; if (status_count_s !== ((i < 3) ? 2'(i + 1) : 2'd3)) begin errors++; $display("FAIL sat_count_s[%0d] got %0d want %0d", i, status_count_s, (i < 3) ? i + 1 : 3); end
         vectors++; if (status_count !== 8'(i + 1)) begin errors++; $display("FAIL sat_count[%0d] got %0d want %0d", i, status_count, i + 1); end
         vectors++; if (request_renew_s !== 1'b1) begin errors++; $display("FAIL sat_request[%0d] got %b want 1", i, request_renew_s); end
      end
   endtask

   task automatic test_reset_in_flight();
      apply(0);
      bus.correct_valid = 1'b1;
      tick();
      bus.correct_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      vectors++; if (request_renew !== 1'b1 || status_count !== 8'd0) begin errors++; $display("FAIL rif_state got %b/%0d want 1/0", request_renew, status_count); end
      #1 rst_n = 1'b1;
      tick();
      vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rif_discard got %b want 0", bus.out_valid); end
   endtask

   initial begin
      param_enable      = 1'b1;
      param_limit_min   = -64'sd100;
      param_limit_max   = 64'sd100;
      param_renew_count = 8'd3;
      current_time      = 64'd0;
      bus.correct_time  = 64'd0;
      bus.correct_renew = 1'b0;
      bus.correct_valid = 1'b0;

      test_reset();
      test_in_range();
      test_threshold();
      test_counter_reset();
      test_wrap();
      test_back_to_back();
      test_disable();
      test_saturation();
      test_reset_in_flight();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/jellyvl_synctimer_limitter_hys.md
# jellyvl_synctimer_limitter_hys

Correction-range limiter for the sync-timer chain, sitting between the correction-time source and the timer adjuster. For each correction sample it computes the signed offset from the local timer and clamps it to a programmable window. It requests a full timer renewal only after a programmable number of consecutive out-of-range samples, so isolated outliers no longer force a renewal. The clamped offset and per-sample over/under flags go downstream.

## Interface
Parameters:
- TIMER_WIDTH, 64, timer bit width
- LIMIT_WIDTH, TIMER_WIDTH, limit and clamped-offset width; must be ≤ TIMER_WIDTH
- COUNT_WIDTH, 8, width of the consecutive-violation counter and its threshold
- INIT_OVERRIDE, 1, reset value of request_renew

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset, asynchronous assert, active-low
- param_enable  in  1  1 = violation counting enabled
- param_limit_min  in  LIMIT_WIDTH signed  lower bound of accepted offset
- param_limit_max  in  LIMIT_WIDTH signed  upper bound of accepted offset
- param_renew_count  in  COUNT_WIDTH  consecutive violations needed to request renewal; 0 behaves as 1
- current_time  in  TIMER_WIDTH  local timer
- correct_time  in  TIMER_WIDTH  correction sample
- correct_renew  in  1  sample is itself a renewal (overwrite)
- correct_valid  in  1  sample strobe
- request_renew  out  1  level request for a renewal sample
- out_diff  out  LIMIT_WIDTH signed  clamped offset
- out_renew  out  1  copy of correct_renew for this sample
- out_over / out_under  out  1  sample was above max / below min
- out_valid  out  1  output strobe
- status_count  out  COUNT_WIDTH  current consecutive-violation count

## Operation
- Stage 1 registers the following on every clock:
  - diff = signed TIMER_WIDTH (correct_time − current_time), using modulo-2^TIMER_WIDTH wrap
  - d_renew = correct_renew
  - d_valid = correct_valid
- Compare against the limits sign-extended to TIMER_WIDTH:
  - under = diff < min
  - over = !under && diff > max
  - With min > max, every sample reports under or over.
- Stage 2 registers the outputs from the stage-1 registers when d_valid = 1:
  - out_diff = min if under, max if over, otherwise diff truncated to LIMIT_WIDTH
  - out_over, out_under as computed
  - out_renew = d_renew
  - out_valid = 1
- When d_valid = 0: out_valid = 0 and the other outputs hold.
- Violation counter, updated on d_valid:
  - d_renew = 1 or param_enable = 0: counter ← 0
  - (over | under): counter ← counter + 1, saturating at 2^COUNT_WIDTH − 1
  - otherwise: counter ← 0
  - Renewal trigger: when (over | under) and counter + 1 ≥ max(param_renew_count, 1), set request_renew.
- request_renew:
  - Cleared on the edge following any accepted correct_valid, renew or not.
  - When a set and a clear hit the same edge, the set wins.
  - Stays high until cleared.
- out_renew, out_over and out_under are computed even when param_enable = 0; only the counter and the renewal trigger are gated by param_enable.

## Timing
- Reset values:
  - request_renew = INIT_OVERRIDE
  - out_valid = 0, out_over = 0, out_under = 0, out_renew = 0
  - out_diff = 0, status_count = 0
  - all stage-1 registers = 0
- Latency:
  - correct_valid at edge k produces out_valid at edge k+2.
  - request_renew set by that sample is visible after edge k+2.
  - request_renew cleared by that sample is visible after edge k+1.
- Throughput: one sample per cycle, back-to-back; no back-pressure.
- A sample in flight when rst_n falls is discarded. After rst_n rises, the first output appears no earlier than 2 edges after the first accepted correct_valid.
- Parameter changes take effect on the first sample evaluated at stage 1 after the change.

## Test plan
- **Reset / first sample.** Reset with INIT_OVERRIDE = 1 → request_renew = 1. Send one renew sample (correct_valid = 1, correct_renew = 1) → request_renew = 0 one edge later; out_valid = 1 and out_renew = 1 two edges later.
- **In-range sample.** min = −100, max = 100, diff = +50 → out_diff = 50, no flags, status_count = 0, request_renew stays 0.
- **Threshold of 3.** param_renew_count = 3; samples with diff = +500, +500, +500:
  - out_diff = 100 and out_over = 1 for each
  - status_count goes 1, 2, 3
  - request_renew rises after the third output edge only
- **Counter reset by good sample.** Diffs −300, −300, 0, −300 with threshold 3 → counter goes 1, 2, 0, 1; no renewal; the first −300 gives out_diff = −100 with out_under = 1.
- **Wrap-around.** TIMER_WIDTH = 64, current_time = 0xFFFF_FFFF_FFFF_FFF0, correct_time = 0x10 → diff = +32 → in range, out_diff = 32.
- **Simultaneous set/clear, disable, saturation.**
  - A violating sample with threshold 1 reaches stage 2 on the same edge a new correct_valid arrives → request_renew = 1 (set wins).
  - With param_enable = 0 → counter held at 0 and no renewal.
  - COUNT_WIDTH = 2 with 5 violations and threshold 0 → counter saturates at 3.
